// File: rtl/aes_pkg.sv
// Shared AES constants, the word-I/O state type and word slot helpers.
package aes_pkg;

  localparam int AES_BLK_W   = 128;
  localparam int AES_WORD_W  = 32;
  localparam int AES_WORDS   = 4;
  localparam int AES_CIP_LAT = 10;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } aes_io_state_t;

  // Slot 0 is the most significant word (FIPS-197 byte 0 is the MSB).
  function automatic logic [AES_BLK_W-1:0] put_word(
    input logic [AES_BLK_W-1:0]  blk,
    input logic [1:0]            slot,
    input logic [AES_WORD_W-1:0] w
  );
    logic [AES_BLK_W-1:0] r;
    r = blk;
    case (slot)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  function automatic logic [AES_WORD_W-1:0] get_word(
    input logic [AES_BLK_W-1:0] blk,
    input logic [1:0]           slot
  );
    logic [AES_WORD_W-1:0] w;
    case (slot)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_word_io.sv
// Word-serial front/back end for the unrolled AES-128 cipher: packs four
// input words into a block, holds it on cip_data for the cipher latency,
// captures the result and streams it back as four words.
//
// Handshakes: a word moves on a rising edge where valid & ready are both
// high; valid may not depend on ready, and in_ready/out_valid/busy are
// decoded from the state register only.
module aes_word_io
  import aes_pkg::*;
#(
  parameter int WORD_W  = AES_WORD_W,
  parameter int CIP_LAT = AES_CIP_LAT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_W-1:0]    in_word,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [AES_BLK_W-1:0] cip_data,
  input  logic [AES_BLK_W-1:0] cip_out,
  output logic [WORD_W-1:0]    out_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(CIP_LAT + 1);

  aes_io_state_t        state, state_n;
  logic [1:0]           cnt;
  logic [1:0]           idx;
  logic [CW-1:0]        wcnt;
  logic [AES_BLK_W-1:0] pack;
  logic [AES_BLK_W-1:0] res;

  logic in_xfer, out_xfer;

  assign in_xfer  = (state == LOAD) && in_valid;
  assign out_xfer = (state == DRAIN) && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_n;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt == 2'd3) state_n = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (wcnt == CW'(1)) state_n = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && idx == 2'd3) state_n = LOAD;
      end
      default: state_n = LOAD;
    endcase
  end

  assign dbg_state = state;

  // Datapath: pack register, cipher drive, wait counter, result and output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 2'd0;
      idx      <= 2'd0;
      wcnt     <= '0;
      pack     <= '0;
      res      <= '0;
      cip_data <= '0;
      out_word <= '0;
    end else begin
      if (in_xfer) begin
        pack <= put_word(pack, cnt, in_word);
        cnt  <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          // The last word goes straight into the cipher block this edge.
          cip_data <= put_word(pack, 2'd3, in_word);
          wcnt     <= CW'(CIP_LAT);
        end
      end
      if (state == WAIT) begin
        wcnt <= wcnt - CW'(1);
        if (wcnt == CW'(1)) begin
          res      <= cip_out;
          idx      <= 2'd0;
          out_word <= get_word(cip_out, 2'd0);
        end
      end
      if (out_xfer) begin
        idx <= idx + 2'd1;
        if (idx != 2'd3) out_word <= get_word(res, idx + 2'd1);
      end
    end
  end

endmodule

// File: tb/tb_aes_word_io.sv
// Directed bench for aes_word_io with a stub cipher driving cip_out.
module tb_aes_word_io;
  import aes_pkg::*;

  localparam int LAT = 10;

  logic         clk;
  logic         rst_n;
  logic [31:0]  in_word;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] cip_data;
  logic [127:0] cip_out;
  logic [31:0]  out_word;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  aes_word_io #(.WORD_W(32), .CIP_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cip_data  (cip_data),
    .cip_out   (cip_out),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sends one block, waits out the cipher latency, drains the result.
  task automatic run_block(input logic [127:0] blk, input logic [127:0] res,
                           input int gap, input int bp, input bit junk);
    int early;
    logic [31:0] exp_w;
    cip_out = ~res;
    for (int i = 0; i < 4; i++) begin
      repeat (gap) begin
        @(posedge clk); #1;
      end
      in_word  = blk[127-32*i -: 32];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    checks++;
    if (cip_data !== blk) begin
      errors++; $display("FAIL cip_data_packed: got %h want %h", cip_data, blk);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL wait_flags: in_ready %b busy %b out_valid %b want 0 1 0",
                         in_ready, busy, out_valid);
    end
    if (junk) begin
      in_valid = 1'b1;
      in_word  = 32'hdeadbeef;
    end
    early = 0;
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || cip_data !== blk) early++;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL wait_window: %0d bad cycles want 0", early);
    end
    cip_out = res;
    @(posedge clk); #1;
    cip_out = 128'h0badf00d_0badf00d_0badf00d_0badf00d;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL result_timing: out_valid %b busy %b want 1 1", out_valid, busy);
    end
    for (int i = 0; i < 4; i++) begin
      exp_w = res[127-32*i -: 32];
      checks++;
      if (out_word !== exp_w || out_valid !== 1'b1) begin
        errors++; $display("FAIL out_word%0d: got %h v%b want %h v1", i, out_word, out_valid, exp_w);
      end
      if (i == 1 && bp > 0) begin
        out_ready = 1'b0;
        for (int c = 0; c < bp; c++) begin
          @(posedge clk); #1;
          checks++;
          if (out_word !== exp_w || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL backpressure_hold: got %h v%b r%b want %h v1 r0",
                               out_word, out_valid, in_ready, exp_w);
          end
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== LOAD) begin
      errors++; $display("FAIL back_to_load: v%b r%b busy%b state %0d want 0 1 0 0",
                         out_valid, in_ready, busy, dbg_state);
    end
    checks++;
    if (cip_data !== blk) begin
      errors++; $display("FAIL cip_data_held: got %h want %h", cip_data, blk);
    end
  endtask

  task automatic test_reset;
    in_word = '0; in_valid = 1'b0; out_ready = 1'b0; cip_out = '0; rst_n = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        cip_data !== 128'h0 || out_word !== 32'h0 || dbg_state !== LOAD) begin
      errors++; $display("FAIL reset_state: r%b v%b busy%b cip %h ow %h st %0d",
                         in_ready, out_valid, busy, cip_data, out_word, dbg_state);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    run_block(128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure;
    run_block(128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 3, 5, 1'b0);
  endtask

  task automatic test_reset_mid_wait;
    for (int i = 0; i < 4; i++) begin
      in_word  = 32'h11111111 * (i + 1);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dbg_state !== LOAD || cip_data !== 128'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_wait: st %0d cip %h busy%b r%b want 0 0 0 1",
                         dbg_state, cip_data, busy, in_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    run_block(128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32, 0, 0, 1'b0);
  endtask

  task automatic test_ignored_inputs;
    run_block(128'h0123456789abcdeffedcba9876543210,
              128'hcafef00d12345678a5a5a5a55a5a5a5a, 1, 2, 1'b1);
    run_block(128'h00112233445566778899aabbccddeeff,
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_backpressure;
    test_reset_mid_wait;
    test_ignored_inputs;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_word_io.md
# aes_word_io

Word-serial front/back end for the unrolled AES-128 cipher. Packs four 32-bit words from the RISC-V side into one 128-bit plaintext block, and drives that block onto the cipher's data input. It holds the block stable for the cipher's fixed pipeline latency, captures the 128-bit result, then returns it as four 32-bit words. One block is in flight at a time.

## Interface
- `WORD_W`, default 32: word width; fixed at 32, with a 128/32 = 4 words-per-block relation.
- `CIP_LAT`, default 10: clock edges from a new block appearing on `cip_data` to a valid result on `cip_out`. Must be ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_word`  in  32  plaintext word.
- `in_valid`  in  1  `in_word` is valid.
- `in_ready`  out  1  block accepts a word; transfer occurs when `in_valid & in_ready` at a rising edge.
- `cip_data`  out  128  block driven to the cipher data input (registered).
- `cip_out`  in  128  cipher result.
- `out_word`  out  32  ciphertext word (registered).
- `out_valid`  out  1  `out_word` is valid.
- `out_ready`  in  1  consumer accepts; transfer occurs when `out_valid & out_ready` at a rising edge.
- `busy`  out  1  high in WAIT or DRAIN.

## Operation
- **FSM states:** LOAD, WAIT, DRAIN. Reset state is LOAD.
- **LOAD:**
  - `in_ready=1`.
  - Each input transfer writes `in_word` into the pack register slot selected by the 2-bit word count.
  - Word 0 goes to bits [127:96], word 1 to [95:64], word 2 to [63:32], word 3 to [31:0] (FIPS-197 byte 0 is the MSB).
  - The count increments on each transfer.
  - On the 4th transfer: `cip_data` takes the full block, counting the word written this edge; the wait counter loads `CIP_LAT`; count wraps to 0; the FSM goes to WAIT.
- **WAIT:**
  - `in_ready=0`, `out_valid=0`.
  - `cip_data` is held stable.
  - The counter decrements each edge.
  - On the edge where the counter equals 1, the result register captures `cip_out`, the FSM goes to DRAIN, and the out index is set to 0.
- **DRAIN:**
  - `out_valid=1`.
  - `out_word` = result word at the out index, in the same MSB-first order as input.
  - Each output transfer advances the index.
  - On the 4th transfer, `out_valid` drops on the same edge and the FSM returns to LOAD.
  - `cip_data` keeps its last value until the next block completes.
- **Boundaries:**
  - `in_valid` gaps in LOAD: the count holds.
  - Words presented while `in_ready=0` are not consumed.
  - `out_ready` low in DRAIN: `out_word` and the index hold indefinitely.
  - Changes on `cip_out` after capture have no effect.
  - Reset asserted in any state forces all of the following immediately: state LOAD, count 0, index 0, counter 0, pack register 0, result register 0, `cip_data=0`, `out_word=0`, `out_valid=0`, `busy=0`, `in_ready=1`.

## Timing
- **Input latency:** the 4th input transfer at edge N makes the new `cip_data` visible after N.
- **Result timing:** `cip_out` is sampled at edge N+`CIP_LAT`. `out_valid` rises after that edge with word 0 presented.
- **Minimum block period:** 4 + `CIP_LAT` + 4 cycles with no backpressure. There is no overlap between LOAD and DRAIN.
- **Output drive:** `in_ready`, `out_valid` and `busy` are decoded from the state register only. There is no combinational path from `in_valid` or `out_ready` to any output.
- **Counter width:** the wait counter is $clog2(`CIP_LAT`+1) bits. The word count and out index are 2 bits each and wrap naturally.

## Structure
- **Shared package `aes_pkg`:**
  - `AES_BLK_W`=128.
  - `AES_WORD_W`=32.
  - `AES_WORDS`=4.
  - `AES_CIP_LAT`=10, used as the default for `CIP_LAT`.
  - The enum type `aes_io_state_t` {LOAD, WAIT, DRAIN}.
- **Sub-modules:** none. The FSM, counters and the pack/result registers live in one module.

## Test plan
- **Reset:** assert `rst_n=0` mid-cycle. Immediately: `in_ready=1`, `out_valid=0`, `busy=0`, `cip_data=0`, `out_word=0`.
- **Back-to-back load:** send 00112233, 44556677, 8899aabb, ccddeeff back-to-back. Expect `cip_data`=00112233445566778899aabbccddeeff after the 4th edge, `in_ready=0`, `busy=1`.
- **Result capture:** a stub drives `cip_out`=69c4e0d86a7b0430d8cdb78070b4c55a, which differs from the value just before capture. Expect `out_valid` exactly `CIP_LAT` cycles after the 4th input transfer. Expect words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a in order with `out_ready=1`, then a return to LOAD.
- **Backpressure:** hold `out_ready=0` for 5 cycles after word 1. Expect `out_word`=6a7b0430 stable and `in_ready=0`. Then accept the remaining words in order. Separately, insert 3-cycle `in_valid` gaps between input words; the packed block must be identical to the back-to-back case.
- **Reset mid-WAIT:** pulse `rst_n` low 2 cycles into WAIT. Expect state LOAD and `cip_data=0`. A following full block must produce correct results with the full `CIP_LAT` wait.
- **Ignored inputs:** toggle `in_word`/`in_valid` during WAIT and DRAIN. Expect no change to the pack register or to the next block's contents.
